pipeline_fetch_stage: RTL and testbench
=======================================

# pipeline_fetch_stage

Instruction fetch stage that produces every field the fetch/decode pipeline latch captures.
- Holds the PC and drives the instruction-memory request.
- Absorbs wait states and downstream stalls in a one-entry hold buffer.
- Executes redirects from later stages and tells the latch when to load (write) and when to insert a bubble (flush).
- Sits between the instruction cache port and the fetch/decode latch.

## Interface
Parameters:
- PC_RESET, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  clock. One clock domain; all state updates on posedge CLK.
- nRST  in  1  reset. Asynchronous, active-low.
- imemREN  out  1  instruction read request.
- imemaddr  out  32  fetch address; held stable while imemREN=1 and ihit=0.
- ihit  in  1  memory returns imemload this cycle.
- imemload  in  32  instruction word.
- stall_i  in  1  downstream cannot accept a new instruction this cycle.
- redirect_i  in  1  later stage requests a PC change (branch taken or jump).
- redirect_pc_i  in  32  target PC, word aligned.
- fd_write_o  out  1  latch loads outputs below at this edge (latch pause = !fd_write_o).
- fd_flush_o  out  1  latch loads a bubble (all zero) at this edge.
- instruction_o  out  32  instruction to latch.
- pcplus4_o  out  32  fetched PC + 4.
- addr_top_four_o  out  4  pcplus4_o[31:28], used for jump target formation.

## Operation
States:
- FETCH: request outstanding at PC.
- HOLD: instruction buffered, downstream stalled.
- SQUASH: outstanding request is on a wrong path; wait for its ihit, then discard it.
- HALTED: only with the configuration macro.

Transitions and outputs by state. Priority in every state: redirect_i > stall_i > ihit.
- FETCH, imemREN=1, imemaddr=PC:
  - redirect_i with ihit: fd_flush_o=1, discard the word, PC<=redirect_pc_i, stay in FETCH.
  - redirect_i without ihit: fd_flush_o=1, save the target, go to SQUASH.
  - ihit with !stall_i: fd_write_o=1, outputs = imemload, PC+4, (PC+4)[31:28]; PC<=PC+4.
  - ihit with stall_i: capture imemload and PC+4 into the buffer, PC<=PC+4, go to HOLD.
- HOLD, imemREN=0:
  - !stall_i: fd_write_o=1 with the buffered values, go to FETCH.
  - redirect_i: fd_flush_o=1, drop the buffer, PC<=redirect_pc_i, go to FETCH.
- SQUASH, imemREN=1 at the old address:
  - on ihit: discard the word, PC<=saved target, go to FETCH.
  - a second redirect_i while in SQUASH overwrites the saved target; fd_flush_o=1.
- fd_write_o and fd_flush_o are never both 1. Both are 0 in any cycle with no delivered instruction and no redirect.
- PC arithmetic is 32-bit modulo: PC 32'hFFFF_FFFC + 4 = 32'h0000_0000.

## Timing
- Reset state: PC=PC_RESET, state FETCH, buffer=0.
- Output reset values: imemREN=1, imemaddr=PC_RESET, fd_write_o=0, fd_flush_o=0, instruction_o=0, pcplus4_o=0, addr_top_four_o=0.
- All outputs are combinational from state, buffer, and inputs.
- With zero-wait ihit and no stalls, throughput is one instruction per cycle.
- Latency from ihit to latch capture: same edge.
- Redirect: the target is requested on the cycle after redirect_i, or after ihit when in SQUASH.
- Reset asserted mid-request: the request is abandoned immediately. The first post-reset request is at PC_RESET.

## Configuration
- FETCH_HALT_EN defined:
  - A delivered instruction equal to HALT_INSTR is written to the latch normally, then the state goes to HALTED.
  - In HALTED: imemREN=0, PC frozen, no further fd_write_o.
  - redirect_i in HALTED: fd_flush_o=1, PC<=redirect_pc_i, go to FETCH (covers a wrong-path halt).
- FETCH_HALT_EN undefined: HALT_INSTR is an ordinary word and the HALTED state does not exist.

## Structure
- cpu_types_pkg: word_t, fetch_state_t (FETCH, HOLD, SQUASH, HALTED), HALT_INSTR = 32'hFFFF_FFFF.
- No sub-module. PC register, hold buffer and FSM are a single module.

## Test plan
- Reset release, ihit every cycle: imemaddr 0, 4, 8; fd_write_o=1 each cycle; pcplus4_o 4, 8, 12.
- ihit with stall_i held 3 cycles at PC=0x10, imemload=0x2002000A: HOLD, imemREN=0. On release, one fd_write_o with instruction 0x2002000A and pcplus4_o 0x14; next request at 0x14.
- redirect_i to 0x40 while FETCH waits (ihit low) at 0x20: fd_flush_o=1; imemaddr stays 0x20 until ihit; that word is discarded; next request at 0x40.
- redirect_i coinciding with ihit at 0x24: fd_flush_o=1, fd_write_o=0, next imemaddr=redirect_pc_i.
- PC=0xFFFF_FFFC with ihit: pcplus4_o=0, addr_top_four_o=0, next imemaddr=0.
- FETCH_HALT_EN, HALT_INSTR at 0x8: written once, then imemREN=0 indefinitely. A following redirect_i to 0x100 resumes fetching at 0x100.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared fetch/decode types: word type, fetch FSM states and the halt encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    SQUASH,
    HALTED
  } fetch_state_t;

  localparam word_t HALT_INSTR = 32'hFFFF_FFFF;

endpackage

// File: rtl/pipeline_fetch_stage.sv
// Instruction fetch stage: PC, imem request, one-entry hold buffer and redirect squash.
// Optional halt-on-HALT_INSTR behaviour is enabled by defining FETCH_HALT_EN.
module pipeline_fetch_stage
  import cpu_types_pkg::*;
#(
  parameter word_t PC_RESET = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        nRST,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  input  logic        ihit,
  input  logic [31:0] imemload,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        fd_write_o,
  output logic        fd_flush_o,
  output logic [31:0] instruction_o,
  output logic [31:0] pcplus4_o,
  output logic [3:0]  addr_top_four_o
);

  fetch_state_t state, state_n;
  word_t        pc, pc_n;
  word_t        target, target_n;
  word_t        buf_instr, buf_instr_n;
  word_t        buf_pcplus4, buf_pcplus4_n;
  word_t        pc_plus4;

  assign pc_plus4        = pc + 32'd4;
  assign addr_top_four_o = pcplus4_o[31:28];

  always_comb begin
    state_n       = state;
    pc_n          = pc;
    target_n      = target;
    buf_instr_n   = buf_instr;
    buf_pcplus4_n = buf_pcplus4;
    imemREN       = 1'b1;
    imemaddr      = pc;
    fd_write_o    = 1'b0;
    fd_flush_o    = 1'b0;
    instruction_o = '0;
    pcplus4_o     = '0;

    case (state)
      FETCH: begin
        if (redirect_i) begin
          fd_flush_o = 1'b1;
          if (ihit) begin
            pc_n = redirect_pc_i;
          end else begin
            target_n = redirect_pc_i;
            state_n  = SQUASH;
          end
        end else if (ihit) begin
          pc_n = pc_plus4;
          if (stall_i) begin
            buf_instr_n   = imemload;
            buf_pcplus4_n = pc_plus4;
            state_n       = HOLD;
          end else begin
            fd_write_o    = 1'b1;
            instruction_o = imemload;
            pcplus4_o     = pc_plus4;
`ifdef FETCH_HALT_EN
            if (imemload == HALT_INSTR) state_n = HALTED;
`endif
          end
        end
      end

      HOLD: begin
        imemREN = 1'b0;
        if (redirect_i) begin
          fd_flush_o    = 1'b1;
          buf_instr_n   = '0;
          buf_pcplus4_n = '0;
          pc_n          = redirect_pc_i;
          state_n       = FETCH;
        end else if (!stall_i) begin
          fd_write_o    = 1'b1;
          instruction_o = buf_instr;
          pcplus4_o     = buf_pcplus4;
          buf_instr_n   = '0;
          buf_pcplus4_n = '0;
          state_n       = FETCH;
`ifdef FETCH_HALT_EN
          if (buf_instr == HALT_INSTR) state_n = HALTED;
`endif
        end
      end

      // The wrong-path request stays on the bus until memory answers; a newer
      // redirect only replaces the target used once that answer arrives.
      SQUASH: begin
        if (redirect_i) begin
          fd_flush_o = 1'b1;
          target_n   = redirect_pc_i;
        end
        if (ihit) begin
          pc_n    = redirect_i ? redirect_pc_i : target;
          state_n = FETCH;
        end
      end

`ifdef FETCH_HALT_EN
      HALTED: begin
        imemREN = 1'b0;
        if (redirect_i) begin
          fd_flush_o = 1'b1;
          pc_n       = redirect_pc_i;
          state_n    = FETCH;
        end
      end
`endif

      default: state_n = FETCH;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state       <= FETCH;
      pc          <= PC_RESET;
      target      <= '0;
      buf_instr   <= '0;
      buf_pcplus4 <= '0;
    end else begin
      state       <= state_n;
      pc          <= pc_n;
      target      <= target_n;
      buf_instr   <= buf_instr_n;
      buf_pcplus4 <= buf_pcplus4_n;
    end
  end

endmodule

// File: tb/tb_pipeline_fetch_stage.sv
// Scoreboarded bench for pipeline_fetch_stage: directed test-plan sequences, then random traffic.
// Build with FETCH_HALT_EN defined to exercise the halt behaviour.
module tb_pipeline_fetch_stage;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        fd_write_o;
  logic        fd_flush_o;
  logic [31:0] instruction_o;
  logic [31:0] pcplus4_o;
  logic [3:0]  addr_top_four_o;

  pipeline_fetch_stage #(.PC_RESET(32'h0000_0000)) dut (
    .CLK(CLK), .nRST(nRST),
    .imemREN(imemREN), .imemaddr(imemaddr), .ihit(ihit), .imemload(imemload),
    .stall_i(stall_i), .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .fd_write_o(fd_write_o), .fd_flush_o(fd_flush_o), .instruction_o(instruction_o),
    .pcplus4_o(pcplus4_o), .addr_top_four_o(addr_top_four_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          cyc;
    logic        flush;
    logic [31:0] instr;
    logic [31:0] pcp4;
  } ev_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pcp4;
  } held_t;

  ev_t   sbq[$];
  held_t hq[$];
  int    checks = 0;
  int    failures = 0;
  int    cyc = 0;

  // Reference model: address of the next request, an optional wrong-path
  // request awaiting its answer, parked instructions, and a halted flag.
  logic [31:0] m_pc;
  logic [31:0] m_tgt;
  bit          m_wrong;
  bit          m_halted;

  function automatic logic [31:0] mem(input logic [31:0] a);
    logic [31:0] w;
    w = (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    w[0] = 1'b0;
    if (a == 32'h10) w = 32'h2002_000A;
`ifdef FETCH_HALT_EN
    if (a == 32'h8) w = HALT_WORD;
`endif
    return w;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic expect_event(input bit fl, input logic [31:0] i, input logic [31:0] p);
    ev_t e;
    e.cyc = cyc; e.flush = fl; e.instr = i; e.pcp4 = p;
    sbq.push_back(e);
`ifdef FETCH_HALT_EN
    if (!fl && i == HALT_WORD) m_halted = 1'b1;
`endif
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_tgt = 32'h0; m_wrong = 1'b0; m_halted = 1'b0;
    hq.delete();
  endtask

  // One clock of stimulus: drive, check the request, record expectations, advance the model.
  task automatic step(input bit r, input logic [31:0] rpc, input bit s, input bit h);
    bit          req;
    logic [31:0] w;
    held_t       hd;
    @(posedge CLK); #1;
    cyc++;
    req = !(m_halted || hq.size() > 0);
    if (!req) h = 1'b0;
    w = mem(m_pc);
    redirect_i = r; redirect_pc_i = rpc; stall_i = s; ihit = h;
    imemload = h ? w : $urandom;
    #1;
    check("imemREN", {31'b0, imemREN}, {31'b0, req});
    if (req) check("imemaddr", imemaddr, m_pc);

    if (m_halted) begin
      if (r) begin expect_event(1'b1, '0, '0); m_pc = rpc; m_halted = 1'b0; end
    end else if (hq.size() > 0) begin
      if (r) begin
        expect_event(1'b1, '0, '0); hq.delete(); m_pc = rpc;
      end else if (!s) begin
        hd = hq.pop_front();
        expect_event(1'b0, hd.instr, hd.pcp4);
      end
    end else if (m_wrong) begin
      if (r) begin expect_event(1'b1, '0, '0); m_tgt = rpc; end
      if (h) begin m_pc = m_tgt; m_wrong = 1'b0; end
    end else begin
      if (r) begin
        expect_event(1'b1, '0, '0);
        if (h) m_pc = rpc;
        else begin m_wrong = 1'b1; m_tgt = rpc; end
      end else if (h) begin
        if (s) hq.push_back('{w, m_pc + 32'd4});
        else expect_event(1'b0, w, m_pc + 32'd4);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin : monitor
    ev_t e;
    forever begin
      @(negedge CLK);
      if (nRST && (fd_write_o || fd_flush_o)) begin
        check("write_flush_exclusive", {31'b0, fd_write_o & fd_flush_o}, 32'h0);
        if (sbq.size() == 0) begin
          check("unexpected_output", {30'b0, fd_write_o, fd_flush_o}, 32'h0);
        end else begin
          e = sbq.pop_front();
          check("event_cycle", cyc, e.cyc);
          check("fd_flush_o", {31'b0, fd_flush_o}, {31'b0, e.flush});
          check("fd_write_o", {31'b0, fd_write_o}, {31'b0, !e.flush});
          check("instruction_o", instruction_o, e.instr);
          check("pcplus4_o", pcplus4_o, e.pcp4);
          check("addr_top_four_o", {28'b0, addr_top_four_o}, {28'b0, e.pcp4[31:28]});
        end
      end
    end
  end

  initial begin
    nRST = 1'b0; ihit = 1'b0; imemload = '0; stall_i = 1'b0;
    redirect_i = 1'b0; redirect_pc_i = '0;
    model_reset();
    #12;
    check("rst_imemREN", {31'b0, imemREN}, 32'h1);
    check("rst_imemaddr", imemaddr, 32'h0);
    check("rst_fd_write_o", {31'b0, fd_write_o}, 32'h0);
    check("rst_fd_flush_o", {31'b0, fd_flush_o}, 32'h0);
    check("rst_instruction_o", instruction_o, 32'h0);
    check("rst_pcplus4_o", pcplus4_o, 32'h0);
    check("rst_addr_top_four_o", {28'b0, addr_top_four_o}, 32'h0);
    @(posedge CLK); #1; nRST = 1'b1;

    // Zero-wait stream 0, 4, 8 (HALT at 8 when the halt feature is built in)
    step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    // Redirect to 0x100, resolved by the next answer, then jump to 0x10
    step(1, 32'h100, 0, 0); step(0, 0, 0, 1);
    step(1, 32'h10, 0, 1);
    // Stall with a hit at 0x10, held for three cycles, then released
    step(0, 0, 1, 1); step(0, 0, 1, 0); step(0, 0, 1, 0);
    step(0, 0, 0, 0); step(0, 0, 0, 0);
    // Redirect from 0x14 to 0x20, then wrong-path squash at 0x20 towards 0x40
    step(1, 32'h20, 0, 1);
    step(1, 32'h40, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 0); step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    // Redirect coinciding with a hit at 0x24
    step(1, 32'h24, 0, 1); step(1, 32'h80, 0, 1); step(0, 0, 0, 0);
    // PC wrap-around at the top of the address space
    step(1, 32'hFFFF_FFFC, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 1);
    // Second redirect while squashing
    step(1, 32'h200, 0, 0); step(1, 32'h300, 0, 0); step(0, 0, 0, 1); step(0, 0, 0, 1);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] t;
      t = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFFC;
      if ($urandom_range(0, 31) == 0) t = 32'h0000_0004;
      step($urandom_range(0, 9) == 0, t, $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
    end

    // Abandon an outstanding request by asserting reset mid-cycle
    step(1, 32'h500, 0, 0); step(0, 0, 0, 0);
    @(posedge CLK); #3;
    ihit = 1'b0; redirect_i = 1'b0; stall_i = 1'b0;
    nRST = 1'b0;
    #1;
    check("midrst_imemREN", {31'b0, imemREN}, 32'h1);
    check("midrst_imemaddr", imemaddr, 32'h0);
    check("midrst_fd_write_o", {31'b0, fd_write_o}, 32'h0);
    model_reset();
    @(posedge CLK); #2; nRST = 1'b1;
    step(0, 0, 0, 1); step(0, 0, 0, 1); step(0, 0, 0, 0);

    @(negedge CLK); #1;
    check("scoreboard_empty", sbq.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
